// File: rtl/safecrack_pkg.sv
// safecrack_pkg: shared button constants, conditioner state encoding and press-code helper
package safecrack_pkg;

    localparam logic [3:0] BTN_NONE = 4'b1111;
    localparam int         MAX_BTN  = 32;

    typedef enum logic [4:0] {
        IDLE      = 5'b00001,
        DEB_PRESS = 5'b00010,
        EMIT      = 5'b00100,
        WAIT_REL  = 5'b01000,
        DEB_REL   = 5'b10000
    } cond_state_t;

    // Callers pad unused upper bits with ones so only real buttons can count as pressed
    function automatic logic is_single_press(input logic [MAX_BTN-1:0] code);
        return $countones(~code) == 1;
    endfunction

endpackage

// File: rtl/safecrack_btn_conditioner_sync.sv
// safecrack_sync: SYNC_STAGES-deep per-bit synchroniser for the raw KEY pins, resets to released
module safecrack_sync #(
    parameter int NUM_BTN     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] d,
    output logic [NUM_BTN-1:0] q
);

    logic [SYNC_STAGES-1:0][NUM_BTN-1:0] sync_q, sync_d;

    // Shift the raw pins one stage further down the chain each cycle
    always_comb sync_d = {sync_q[SYNC_STAGES-2:0], d};

    // Chain register; released (all ones) out of reset so no phantom press appears
    always_ff @(posedge clk) begin
        if (!rst) sync_q <= '1;
        else      sync_q <= sync_d;
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/safecrack_btn_conditioner.sv
// safecrack_btn_conditioner: sync + debounce of active-low keys into one-cycle press codes.
// Define SAFECRACK_BTN_AUTOREPEAT_EN to re-emit a held single button every REPEAT_CYCLES.
module safecrack_btn_conditioner
    import safecrack_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_CYCLES   = 25_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_out,
    output logic               btn_valid,
    output logic               multi_press,
    output logic               busy
);

    localparam int CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0]   DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [NUM_BTN-1:0] NONE     = '1;
`ifdef SAFECRACK_BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0]   REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic rep_q, rep_d;
`endif

    cond_state_t        state_q, state_d;
    logic [NUM_BTN-1:0] code_q, code_d, btn_out_q, btn_out_d, sync;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               btn_valid_q, btn_valid_d, multi_q, multi_d, busy_q, busy_d;

    safecrack_sync #(
        .NUM_BTN    (NUM_BTN),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (btn_raw),
        .q  (sync)
    );

    // Next state, debounce counting and registered-output values
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        multi_d = 1'b0;
`ifdef SAFECRACK_BTN_AUTOREPEAT_EN
        rep_d   = 1'b0;
`endif
        case (state_q)
            IDLE: if (sync != NONE) begin
                code_d  = sync;
                cnt_d   = '0;
                state_d = DEB_PRESS;
            end
            DEB_PRESS: if (sync == NONE) state_d = IDLE;
            else if (sync != code_q) begin
                code_d = sync;
                cnt_d  = '0;
            end else if (cnt_q == DEB_LAST) begin
                if (is_single_press({{(MAX_BTN-NUM_BTN){1'b1}}, code_q})) state_d = EMIT;
                else begin
                    multi_d = 1'b1;
                    state_d = WAIT_REL;
                end
            end else cnt_d = cnt_q + CNT_ONE;
            EMIT: begin
                cnt_d   = '0;
                state_d = WAIT_REL;
`ifdef SAFECRACK_BTN_AUTOREPEAT_EN
                rep_d   = 1'b1;
`endif
            end
            WAIT_REL: if (sync == NONE) begin
                cnt_d   = '0;
                state_d = DEB_REL;
            end
`ifdef SAFECRACK_BTN_AUTOREPEAT_EN
            else if (rep_q && sync == code_q) begin
                rep_d = 1'b1;
                if (cnt_q == REP_LAST) begin
                    cnt_d   = '0;
                    state_d = EMIT;
                end else cnt_d = cnt_q + CNT_ONE;
            end
`endif
            DEB_REL: if (sync != NONE) state_d = WAIT_REL;
            else if (cnt_q == DEB_LAST) state_d = IDLE;
            else cnt_d = cnt_q + CNT_ONE;
            default: state_d = IDLE;
        endcase
        btn_valid_d = state_d == EMIT;
        btn_out_d   = (state_d == EMIT) ? code_d : NONE;
        busy_d      = state_d != IDLE;
    end

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            code_q      <= NONE;
            cnt_q       <= '0;
            btn_out_q   <= NONE;
            btn_valid_q <= 1'b0;
            multi_q     <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SAFECRACK_BTN_AUTOREPEAT_EN
            rep_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            cnt_q       <= cnt_d;
            btn_out_q   <= btn_out_d;
            btn_valid_q <= btn_valid_d;
            multi_q     <= multi_d;
            busy_q      <= busy_d;
`ifdef SAFECRACK_BTN_AUTOREPEAT_EN
            rep_q       <= rep_d;
`endif
        end
    end

    assign btn_out     = btn_out_q;
    assign btn_valid   = btn_valid_q;
    assign multi_press = multi_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_safecrack_btn_conditioner.sv
// tb_safecrack_btn_conditioner: table, directed and random checks against a run-length reference model
module tb_safecrack_btn_conditioner;

    localparam int SS = 2;
    localparam int DC = 4;
    localparam int RC = 8;
    localparam logic [3:0] NONE = 4'b1111;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] btn_raw = NONE;
    logic [3:0] btn_out;
    logic       btn_valid, multi_press, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    safecrack_btn_conditioner #(
        .NUM_BTN(4), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .REPEAT_CYCLES(RC)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .btn_out(btn_out), .btn_valid(btn_valid), .multi_press(multi_press), .busy(busy)
    );

    // Reference model: raw delayed SS cycles, then judged by run lengths of identical samples
    logic [3:0] pipe [SS];
    logic       armed, blind, rep_on;
    logic [3:0] run_val, rep_code;
    int         run_len, rep_len;
    logic       e_valid, e_multi, e_busy;
    logic [3:0] e_out;

    int         n_valid, n_multi, tick_no, last_tick;
    logic [3:0] last_code;

    typedef struct {
        logic [3:0] code;
        int         hold;
        int         exp_valid;
        int         exp_multi;
    } vec_t;
    vec_t vecs [10];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SS; i++) pipe[i] = NONE;
        armed = 1'b1; blind = 1'b0; rep_on = 1'b0;
        run_val = NONE; run_len = 0; rep_code = NONE; rep_len = 0;
        e_valid = 1'b0; e_multi = 1'b0; e_busy = 1'b0; e_out = NONE;
    endtask

    task automatic model_step(input logic [3:0] raw, input logic rn);
        logic [3:0] s;
        logic fired;
        if (!rn) begin
            model_reset();
            return;
        end
        s = pipe[SS-1];
        for (int i = SS-1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = raw;
        e_valid = 1'b0; e_multi = 1'b0; e_out = NONE; fired = 1'b0;
        if (blind) begin
            blind = 1'b0;
            run_len = 0;
        end else begin
            if (run_len == 0 || s != run_val) begin
                run_val = s;
                run_len = 1;
            end else run_len++;
            if (armed) begin
                if (s != NONE && run_len == DC + 1) begin
                    armed = 1'b0;
                    fired = 1'b1;
                    if ($countones(~s) == 1) begin
                        e_valid = 1'b1; e_out = s; blind = 1'b1;
                        rep_on = 1'b1; rep_code = s; rep_len = 0;
                    end else begin
                        e_multi = 1'b1;
                        rep_on = 1'b0;
                    end
                end
            end else if (s == NONE && run_len == DC + 1) armed = 1'b1;
`ifdef SAFECRACK_BTN_AUTOREPEAT_EN
            if (!armed && !fired && rep_on) begin
                if (s != rep_code) rep_on = 1'b0;
                else if (rep_len == RC - 1) begin
                    e_valid = 1'b1; e_out = s; blind = 1'b1; rep_len = 0;
                end else rep_len++;
            end
`endif
        end
        e_busy = !armed || s != NONE;
    endtask

    task automatic tick(input logic [3:0] raw, input logic rn);
        btn_raw = raw;
        rst = rn;
        @(posedge clk);
        model_step(raw, rn);
        #1;
        check("btn_out", btn_out, e_out);
        check("btn_valid", {3'b0, btn_valid}, {3'b0, e_valid});
        check("multi_press", {3'b0, multi_press}, {3'b0, e_multi});
        check("busy", {3'b0, busy}, {3'b0, e_busy});
        if (btn_valid) begin
            n_valid++;
            last_tick = tick_no;
            last_code = btn_out;
        end
        if (multi_press) n_multi++;
        tick_no++;
    endtask

    task automatic clear_counts();
        n_valid = 0; n_multi = 0; tick_no = 0; last_tick = -1; last_code = NONE;
    endtask

    initial begin
        vecs[0] = '{4'b1110, 12, 1, 0};
        vecs[1] = '{4'b1101, 12, 1, 0};
        vecs[2] = '{4'b1011, 12, 1, 0};
        vecs[3] = '{4'b0111, 12, 1, 0};
        vecs[4] = '{4'b1010, 12, 0, 1};
        vecs[5] = '{4'b0000, 12, 0, 1};
        vecs[6] = '{4'b0111,  3, 0, 0};
        vecs[7] = '{4'b1011,  4, 0, 0};
        vecs[8] = '{4'b1011,  5, 1, 0};
        vecs[9] = '{4'b1000,  5, 0, 1};

        model_reset();
        clear_counts();
        repeat (2) tick(NONE, 1'b0);
        check("reset_out", btn_out, NONE);
        check("reset_busy", {3'b0, busy}, 4'h0);
        repeat (10) tick(NONE, 1'b1);

        for (int v = 0; v < 10; v++) begin
            clear_counts();
            repeat (vecs[v].hold) tick(vecs[v].code, 1'b1);
            repeat (12) tick(NONE, 1'b1);
            check_int($sformatf("vec%0d_valid", v), n_valid, vecs[v].exp_valid);
            check_int($sformatf("vec%0d_multi", v), n_multi, vecs[v].exp_multi);
            if (vecs[v].exp_valid != 0) check($sformatf("vec%0d_code", v), last_code, vecs[v].code);
        end

        clear_counts();
        repeat (50) tick(4'b1110, 1'b1);
        check_int("clean_count", n_valid, 1);
        check_int("clean_latency", last_tick, 6);
        check("clean_code", last_code, 4'b1110);
        repeat (10) tick(NONE, 1'b1);

        clear_counts();
        for (int i = 0; i < 12; i++) tick(((i / 2) % 2 == 0) ? 4'b1101 : NONE, 1'b1);
        check_int("bounce_early", n_valid, 0);
        tick_no = 0;
        repeat (30) tick(4'b1101, 1'b1);
        check_int("bounce_count", n_valid, 1);
        check_int("bounce_latency", last_tick, 6);
        check("bounce_code", last_code, 4'b1101);
        repeat (10) tick(NONE, 1'b1);

        clear_counts();
        repeat (20) tick(4'b1100, 1'b1);
        check_int("chord_multi", n_multi, 1);
        check_int("chord_valid", n_valid, 0);
        repeat (10) tick(NONE, 1'b1);

        clear_counts();
        repeat (15) tick(4'b1110, 1'b1);
        check_int("relb_first", n_valid, 1);
        clear_counts();
        tick(NONE, 1'b1); tick(4'b1011, 1'b1); tick(NONE, 1'b1);
        tick(NONE, 1'b1); tick(NONE, 1'b1);
        repeat (20) tick(4'b1011, 1'b1);
        check_int("relb_blocked", n_valid, 0);
        repeat (10) tick(NONE, 1'b1);
        repeat (12) tick(4'b1011, 1'b1);
        check_int("relb_second", n_valid, 1);
        check("relb_code", last_code, 4'b1011);
        repeat (10) tick(NONE, 1'b1);

        clear_counts();
        repeat (4) tick(4'b1110, 1'b1);
        check("rst_mid_busy", {3'b0, busy}, 4'h1);
        tick(NONE, 1'b0);
        check("rst_mid_out", btn_out, NONE);
        check("rst_mid_idle", {2'b0, busy, btn_valid}, 4'h0);
        repeat (20) tick(NONE, 1'b1);
        check_int("rst_mid_events", n_valid, 0);

        clear_counts();
        repeat (7) tick(4'b0111, 1'b1);
        check_int("hold_first", n_valid, 1);
        n_valid = 0;
        repeat (40) tick(4'b0111, 1'b1);
`ifdef SAFECRACK_BTN_AUTOREPEAT_EN
        check_int("hold_repeats", n_valid, 4);
`else
        check_int("hold_repeats", n_valid, 0);
`endif
        repeat (10) tick(NONE, 1'b1);

        for (int seg = 0; seg < 600; seg++) begin
            logic [3:0] val;
            int kind;
            kind = $urandom_range(0, 3);
            val = (kind == 1) ? ~(4'b0001 << $urandom_range(0, 3)) :
                  (kind == 2) ? 4'($urandom_range(0, 15)) : NONE;
            if ($urandom_range(0, 99) == 0) tick(val, 1'b0);
            repeat ($urandom_range(1, 9)) tick(val, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
